uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 The module SHALL have parameter CLOCK_FREQ, default 50_000_000, meaning the clk frequency in Hz.
REQ-002 The module SHALL have parameter BAUD_RATE, default 115200, meaning the serial bit rate in bits/s.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port data_in, input, 8 bits: the byte to transmit.
REQ-006 The module SHALL have port data_in_valid, input, 1 bit: the producer offers data_in.
REQ-007 The module SHALL have port data_in_ready, output, 1 bit: the transmitter can accept a byte.
REQ-008 The module SHALL have port serial_out, output, 1 bit: the UART line, idle high.

Function
REQ-009 SHALL define SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE (integer division), the number of clk cycles per bit; the bit counter SHALL be $clog2(SYMBOL_EDGE_TIME) bits wide.
REQ-010 SHALL use a registered FSM with states IDLE, START, DATA, PARITY (present only per REQ-024), STOP.
REQ-011 data_in_ready SHALL be 1 exactly when state==IDLE and reset is deasserted.
REQ-012 A handshake SHALL occur on a rising edge where data_in_valid && data_in_ready; data_in SHALL be latched into a shift register on that edge, and the FSM SHALL go to START.
REQ-013 Start bit: serial_out SHALL be 0 for exactly SYMBOL_EDGE_TIME cycles, beginning the cycle after the handshake.
REQ-014 DATA: 8 bits, LSB first, each held for exactly SYMBOL_EDGE_TIME cycles; a 3-bit index SHALL count 0..7, then the FSM SHALL exit DATA.
REQ-015 STOP: serial_out SHALL be 1 for exactly SYMBOL_EDGE_TIME cycles, then the FSM SHALL return to IDLE.
REQ-016 serial_out SHALL be driven from a flop; there SHALL be no combinational path from inputs to serial_out.
REQ-017 In IDLE, serial_out SHALL be 1.
REQ-018 data_in and data_in_valid changes outside IDLE SHALL be ignored; the latched byte SHALL be unaffected.
REQ-019 Back-to-back: if data_in_valid is high in the cycle after STOP completes (the IDLE cycle), the next handshake SHALL occur in that cycle, giving exactly one idle-state cycle between frames.
REQ-020 The bit counter SHALL reset to 0 at every bit boundary; it SHALL never wrap mid-bit.

Reset
REQ-021 On reset low, asynchronously: state=IDLE, serial_out=1, bit counter=0, bit index=0, shift register=0.
REQ-022 While reset is low, data_in_ready SHALL be 0 and no handshake SHALL occur.
REQ-023 If reset is asserted mid-frame, the frame SHALL be abandoned, the line SHALL return high immediately, and the first frame after release SHALL be complete and correct.

Configuration
REQ-024 With macro UART_TX_PARITY_EN defined, a PARITY state SHALL follow DATA, driving even parity (XOR of the 8 data bits) for SYMBOL_EDGE_TIME cycles; the frame is 11 bits. Without the macro, DATA SHALL go directly to STOP; the frame is 10 bits and no parity logic is synthesised.

Verification
REQ-025 Single byte: after reset release, send 0x55 with default parameters (SYMBOL_EDGE_TIME=434) -> line sequence 0,1,0,1,0,1,0,1,0,1, each bit 434 cycles; data_in_ready low for 4340 cycles, then high.
REQ-026 Back-to-back: hold data_in_valid high with 0xA3 then 0x0F -> two frames, LSB-first bits 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0; exactly one idle cycle between the stop bit and the next start bit.
REQ-027 Ignore while busy: change data_in to 0xFF mid-frame of 0x00 -> all 8 data bits transmitted as 0.
REQ-028 Mid-frame reset: assert reset at cycle 2000 of a frame -> serial_out=1 and data_in_ready=0 immediately; after release, 0x3C transmits correctly.
REQ-029 Parity (UART_TX_PARITY_EN defined): send 0x07 -> parity bit 1 and frame length 4774 cycles; send 0x03 -> parity bit 0.
REQ-030 Idle: no valid for 10000 cycles -> serial_out constant 1 and data_in_ready constant 1.

Source files
------------

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 UART transmitter with a valid/ready byte input.
//
// Frame: one start bit (0), eight data bits LSB first, optional even parity
// bit, one stop bit (1). Each bit lasts SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE
// clk cycles.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit (11-bit frame). Without it the
// frame is 10 bits and no parity logic exists.
//
// Handshake: a byte is accepted on a rising clk edge where
// data_in_valid && data_in_ready. data_in_ready is high only in IDLE with reset
// released. data_in is captured on that edge. While a frame is in flight,
// data_in and data_in_valid are ignored. The producer may hold data_in_valid
// high across frames; the next byte is then taken in the single IDLE cycle
// that follows each stop bit.
//
// The FSM state is held in the signal 'state' so checkers can bind to it.

`timescale 1ns/1ps

module uart_transmitter #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out
);

    // Cycles per bit, and the width of the in-bit cycle counter.
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;
`endif

    tx_state_t        state;
    logic [CNT_W-1:0] bit_count;
    logic [2:0]       bit_index;
    logic [2:0]       next_index;
    logic [7:0]       shift_reg;
    logic             bit_end;
    logic             handshake;

    // Ready is a pure function of the state flop and the reset pin, so it
    // drops the moment reset is asserted.
    assign data_in_ready = (state == IDLE) && reset;
    assign handshake     = data_in_valid && data_in_ready;

    // The last cycle of the current bit; the counter clears here and nowhere
    // else, so it never wraps inside a bit.
    assign bit_end    = (bit_count == CNT_LAST);
    assign next_index = bit_index + 3'd1;

    // Transmit FSM: state, counters, latched byte and the registered line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            serial_out <= 1'b1;
            bit_count  <= '0;
            bit_index  <= '0;
            shift_reg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bit_count  <= '0;
                    bit_index  <= '0;
                    serial_out <= 1'b1;
                    if (handshake) begin
                        shift_reg  <= data_in;
                        serial_out <= 1'b0;
                        state      <= START;
                    end
                end

                START: begin
                    if (bit_end) begin
                        bit_count  <= '0;
                        bit_index  <= '0;
                        serial_out <= shift_reg[0];
                        state      <= DATA;
                    end else begin
                        bit_count <= bit_count + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        bit_count <= '0;
                        if (bit_index == 3'd7) begin
                            bit_index <= '0;
`ifdef UART_TX_PARITY_EN
                            serial_out <= ^shift_reg;
                            state      <= PARITY;
`else
                            serial_out <= 1'b1;
                            state      <= STOP;
`endif
                        end else begin
                            bit_index  <= next_index;
                            serial_out <= shift_reg[next_index];
                        end
                    end else begin
                        bit_count <= bit_count + 1'b1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        bit_count  <= '0;
                        serial_out <= 1'b1;
                        state      <= STOP;
                    end else begin
                        bit_count <= bit_count + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (bit_end) begin
                        bit_count  <= '0;
                        serial_out <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        bit_count <= bit_count + 1'b1;
                    end
                end

                default: begin
                    bit_count  <= '0;
                    bit_index  <= '0;
                    serial_out <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Testbench for uart_transmitter with default parameters (434 cycles per bit).
// A line monitor decodes every frame and compares it against bytes queued by
// the driver at handshake time. Define UART_TX_PARITY_EN for the parity build.

`timescale 1ns/1ps

module tb_uart_transmitter;

    localparam int SET = 50_000_000 / 115200;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = SET * FRAME_BITS;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       serial_out;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_sent = 0;
    int frames_seen = 0;
    int last_stop_cyc = -1000;
    bit mon_en = 1'b0;

    // {check idle gap before this frame, byte}
    logic [8:0] exp_q[$];

    uart_transmitter dut (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .serial_out    (serial_out)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    // ---------------- checking ----------------
    task automatic check_value(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, actual, expected, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    // Samples one bit period starting at the current negedge; counts any
    // change of the line within the period.
    task automatic sample_bit(output logic v, output int changes);
        v = serial_out;
        changes = 0;
        repeat (SET - 1) begin
            @(negedge clk);
            if (serial_out !== v) changes++;
        end
    endtask

    task automatic rx_frame();
        logic       v;
        int         ch;
        logic [7:0] b;
        logic [8:0] e;
        int         start_cyc;
        start_cyc = cyc;
        b = 8'h00;
        if (exp_q.size() == 0) begin
            check_value("spurious_frame", 32'd1, 32'd0);
            e = 9'h000;
        end else begin
            e = exp_q.pop_front();
        end
        if (e[8]) check_value("idle_gap", start_cyc - last_stop_cyc - 1, 32'd1);
        sample_bit(v, ch);
        check_value("start_bit", {31'd0, v}, 32'd0);
        check_value("start_stable", ch, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sample_bit(v, ch);
            b[i] = v;
            check_value("data_stable", ch, 32'd0);
        end
        check_value("data_byte", {24'd0, b}, {24'd0, e[7:0]});
`ifdef UART_TX_PARITY_EN
        @(negedge clk);
        sample_bit(v, ch);
        check_value("parity_bit", {31'd0, v}, {31'd0, ^e[7:0]});
        check_value("parity_stable", ch, 32'd0);
`endif
        @(negedge clk);
        sample_bit(v, ch);
        check_value("stop_bit", {31'd0, v}, 32'd1);
        check_value("stop_stable", ch, 32'd0);
        last_stop_cyc = cyc;
        frames_seen++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && reset && serial_out === 1'b0) rx_frame();
        end
    end

    // ---------------- driver ----------------
    // Offers byte b, waits for the handshake, then checks how long ready stays
    // low. hold keeps valid asserted afterwards; gap asks the monitor to check
    // the one-cycle idle gap; poke disturbs data_in/valid mid-frame.
    task automatic send(input logic [7:0] b, input bit hold, input bit gap, input bit poke);
        int t;
        int low;
        data_in = b;
        data_in_valid = 1'b1;
        t = 0;
        while (!data_in_ready && t < 10000) begin
            @(negedge clk);
            t++;
        end
        if (!data_in_ready) begin
            check_value("ready_timeout", 32'd0, 32'd1);
            data_in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back({gap, b});
        n_sent++;
        #1;
        if (!hold) data_in_valid = 1'b0;
        low = 0;
        @(negedge clk);
        while (!data_in_ready && low < 6000) begin
            low++;
            if (poke && low == 1000) begin
                data_in = 8'hFF;
                data_in_valid = 1'b1;
            end
            if (poke && low == 1001) data_in_valid = 1'b0;
            @(negedge clk);
        end
        check_value("ready_low_cycles", low, FRAME_CYC);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int bad_line;
        int bad_ready;
        int t;

        // Reset state, and no handshake while reset is low.
        repeat (3) @(negedge clk);
        check_value("rst_serial", {31'd0, serial_out}, 32'd1);
        check_value("rst_ready", {31'd0, data_in_ready}, 32'd0);
        data_in = 8'h99;
        data_in_valid = 1'b1;
        repeat (2) @(negedge clk);
        check_value("rst_valid_ready", {31'd0, data_in_ready}, 32'd0);
        check_value("rst_valid_serial", {31'd0, serial_out}, 32'd1);
        data_in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_value("post_rst_ready", {31'd0, data_in_ready}, 32'd1);
        check_value("post_rst_serial", {31'd0, serial_out}, 32'd1);
        mon_en = 1'b1;

        // Single byte.
        send(8'h55, 1'b0, 1'b0, 1'b0);
        // Back-to-back with valid held high.
        send(8'hA3, 1'b1, 1'b0, 1'b0);
        send(8'h0F, 1'b0, 1'b1, 1'b0);
        // Inputs disturbed while busy.
        send(8'h00, 1'b0, 1'b0, 1'b1);
`ifdef UART_TX_PARITY_EN
        send(8'h07, 1'b0, 1'b0, 1'b0);
        send(8'h03, 1'b0, 1'b0, 1'b0);
`endif
        // A random byte for variety.
        send(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);

        // Mid-frame reset on 0x81: cycle 1999 of the frame is data bit 3 (0).
        mon_en = 1'b0;
        data_in = 8'h81;
        data_in_valid = 1'b1;
        @(posedge clk);
        #1 data_in_valid = 1'b0;
        repeat (2000) @(negedge clk);
        check_value("mid_frame_low", {31'd0, serial_out}, 32'd0);
        reset = 1'b0;
        #1;
        check_value("mid_rst_serial", {31'd0, serial_out}, 32'd1);
        check_value("mid_rst_ready", {31'd0, data_in_ready}, 32'd0);
        data_in = 8'h5A;
        data_in_valid = 1'b1;
        repeat (5) @(negedge clk);
        check_value("mid_rst_hold_ready", {31'd0, data_in_ready}, 32'd0);
        check_value("mid_rst_hold_serial", {31'd0, serial_out}, 32'd1);
        data_in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_value("mid_rel_ready", {31'd0, data_in_ready}, 32'd1);
        check_value("mid_rel_serial", {31'd0, serial_out}, 32'd1);
        mon_en = 1'b1;
        send(8'h3C, 1'b0, 1'b0, 1'b0);

        // Idle: no valid for 10000 cycles.
        bad_line = 0;
        bad_ready = 0;
        repeat (10000) begin
            @(negedge clk);
            if (serial_out !== 1'b1) bad_line++;
            if (data_in_ready !== 1'b1) bad_ready++;
        end
        check_value("idle_line", bad_line, 32'd0);
        check_value("idle_ready", bad_ready, 32'd0);

        // Drain.
        t = 0;
        while (exp_q.size() != 0 && t < 10000) begin
            @(negedge clk);
            t++;
        end
        check_value("sb_drain", exp_q.size(), 32'd0);
        check_value("frames_seen", frames_seen, n_sent);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
